// File: rtl/ifetch_prefetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ifetch_prefetch_queue_pkg
// Brief   : Shared widths, reset PC, FSM encodings and address helper.
// Revision: 1.0 - initial release
// ============================================================================
package ifetch_prefetch_queue_pkg;

    localparam int WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] PF_RESET_PC = 32'h0000_0000;

    localparam logic [1:0] PF_IDLE  = 2'd0;
    localparam logic [1:0] PF_REQ   = 2'd1;
    localparam logic [1:0] PF_DRAIN = 2'd2;

    function automatic logic [WORD_WIDTH-1:0] pf_word_align(input logic [WORD_WIDTH-1:0] addr);
        return {addr[WORD_WIDTH-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_prefetch_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module  : ifetch_prefetch_queue_fifo
// Brief   : DEPTH-entry synchronous FIFO with flush, occupancy count and a
//           combinational head read port.
// Revision: 1.0 - initial release
// ============================================================================
module ifetch_prefetch_queue_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == c_DEPTH);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    // Flush wins over any same-cycle write or read.
    assign w_wr = i_wr_en & ~i_flush & ~o_full;
    assign w_rd = i_rd_en & ~i_flush & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : ifetch_prefetch_queue
// Brief   : Sequential instruction prefetcher: one-outstanding memory request
//           FSM feeding a {pc, instr} queue, flushed by redirects.
// Revision: 1.0 - initial release
// ============================================================================
module ifetch_prefetch_queue
    import ifetch_prefetch_queue_pkg::*;
#(
    parameter int                    DEPTH    = 4,
    parameter logic [WORD_WIDTH-1:0] RESET_PC = PF_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic [WORD_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    input  logic                  redirect_valid,
    input  logic [WORD_WIDTH-1:0] redirect_pc,
    input  logic                  deq_ready,
    output logic                  instr_valid,
    output logic [WORD_WIDTH-1:0] instrF,
    output logic [WORD_WIDTH-1:0] pcF
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

    logic [1:0]              r_state;
    logic [WORD_WIDTH-1:0]   r_fetch_pc;
    logic                    r_mem_req;
    logic [WORD_WIDTH-1:0]   r_mem_addr;

    logic                    w_ack;
    logic                    w_enq;
    logic                    w_deq;
    logic                    w_full;
    logic                    w_empty;
    logic [CW-1:0]           w_count;
    logic [CW-1:0]           w_count_next;
    logic                    w_space;
    logic [WORD_WIDTH-1:0]   w_redirect_pc;
    logic [WORD_WIDTH-1:0]   w_pc_inc;
    logic [2*WORD_WIDTH-1:0] w_head;

    assign w_ack         = r_mem_req & mem_ack;
    assign w_enq         = (r_state == PF_REQ) & w_ack & ~redirect_valid;
    assign w_deq         = ~w_empty & deq_ready & ~redirect_valid;
    assign w_count_next  = w_count + CW'(w_enq) - CW'(w_deq);
    assign w_space       = (w_count_next < c_DEPTH);
    assign w_redirect_pc = pf_word_align(redirect_pc);
    assign w_pc_inc      = r_fetch_pc + 32'd4;

    ifetch_prefetch_queue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*WORD_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (redirect_valid),
        .i_wr_en   (w_enq),
        .i_wr_data ({r_mem_addr, mem_rdata}),
        .i_rd_en   (w_deq),
        .o_rd_data (w_head),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= PF_IDLE;
            r_fetch_pc <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_mem_addr <= RESET_PC;
        end else begin
            case (r_state)
                PF_IDLE: begin
                    // No enqueue happens in IDLE, so a slot exists unless full with no dequeue.
                    if (redirect_valid) begin
                        r_fetch_pc <= w_redirect_pc;
                        r_mem_addr <= w_redirect_pc;
                        r_mem_req  <= 1'b1;
                        r_state    <= PF_REQ;
                    end else if (~w_full | w_deq) begin
                        r_mem_addr <= r_fetch_pc;
                        r_mem_req  <= 1'b1;
                        r_state    <= PF_REQ;
                    end
                end
                PF_REQ: begin
                    if (redirect_valid) begin
                        r_fetch_pc <= w_redirect_pc;
                        if (w_ack) begin
                            r_mem_addr <= w_redirect_pc;
                        end else begin
                            r_state <= PF_DRAIN;
                        end
                    end else if (w_ack) begin
                        r_fetch_pc <= w_pc_inc;
                        if (w_space) begin
                            r_mem_addr <= w_pc_inc;
                        end else begin
                            r_mem_req <= 1'b0;
                            r_state   <= PF_IDLE;
                        end
                    end
                end
                PF_DRAIN: begin
                    // The stale response is discarded; the queue is already empty.
                    if (redirect_valid) begin
                        r_fetch_pc <= w_redirect_pc;
                        if (w_ack) begin
                            r_mem_addr <= w_redirect_pc;
                            r_state    <= PF_REQ;
                        end
                    end else if (w_ack) begin
                        r_mem_addr <= r_fetch_pc;
                        r_state    <= PF_REQ;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= PF_IDLE;
                end
            endcase
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign instr_valid = ~w_empty;
    assign instrF      = w_empty ? '0 : w_head[WORD_WIDTH-1:0];
    assign pcF         = w_empty ? '0 : w_head[2*WORD_WIDTH-1:WORD_WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_ifetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_ifetch_prefetch_queue
// Brief   : Randomized bench for ifetch_prefetch_queue against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ifetch_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        deq_ready;
    logic        instr_valid;
    logic [31:0] instrF;
    logic [31:0] pcF;

    always #5 clk = ~clk;

    ifetch_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .deq_ready      (deq_ready),
        .instr_valid    (instr_valid),
        .instrF         (instrF),
        .pcF            (pcF)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: FIFO of {pc,instr}, one outstanding request, stale flag.
    logic [63:0] m_q[$];
    bit          m_req;
    bit          m_stale;
    logic [31:0] m_addr;
    logic [31:0] m_fpc;

    int mode;
    int r_wait;
    int r_lat;

    task automatic model_reset();
        m_q.delete();
        m_req   = 1'b0;
        m_stale = 1'b0;
        m_addr  = RESET_PC;
        m_fpc   = RESET_PC;
    endtask

    task automatic model_step();
        bit          xfer;
        logic [31:0] npc;
        xfer = m_req && mem_ack;
        if (redirect_valid) begin
            npc = redirect_pc & 32'hFFFF_FFFC;
            m_q.delete();
            m_fpc = npc;
            if (!m_req || xfer) begin
                m_req   = 1'b1;
                m_addr  = npc;
                m_stale = 1'b0;
            end else begin
                m_stale = 1'b1;
            end
        end else begin
            if (m_q.size() > 0 && deq_ready) void'(m_q.pop_front());
            if (xfer) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                    m_addr  = m_fpc;
                end else begin
                    m_q.push_back({m_addr, mem_rdata});
                    m_fpc = m_fpc + 32'd4;
                    if (m_q.size() < DEPTH) m_addr = m_fpc;
                    else m_req = 1'b0;
                end
            end else if (!m_req && m_q.size() < DEPTH) begin
                m_req  = 1'b1;
                m_addr = m_fpc;
            end
        end
    endtask

    task automatic compare_outputs();
        check("mem_req", 64'(mem_req), 64'(m_req));
        if (m_req) check("mem_addr", 64'(mem_addr), 64'(m_addr));
        check("instr_valid", 64'(instr_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("pcF", 64'(pcF), 64'(m_q[0][63:32]));
            check("instrF", 64'(instrF), 64'(m_q[0][31:0]));
        end else begin
            check("pcF_empty", 64'(pcF), 64'd0);
            check("instrF_empty", 64'(instrF), 64'd0);
        end
    endtask

    task automatic drive_inputs();
        case (mode)
            0: begin
                mem_ack = 1'b1; deq_ready = 1'b0; redirect_valid = 1'b0;
                mem_rdata = mem_addr ^ 32'hA5A5_0000;
            end
            1: begin
                mem_ack = 1'b1; deq_ready = 1'b1; redirect_valid = 1'b0;
                mem_rdata = mem_addr ^ 32'hA5A5_0000;
            end
            default: begin
                if (mem_req) begin
                    if (r_wait >= r_lat) begin
                        mem_ack = 1'b1;
                        r_wait  = 0;
                        r_lat   = $urandom_range(0, 3);
                    end else begin
                        mem_ack = 1'b0;
                        r_wait++;
                    end
                end else begin
                    mem_ack = 1'b0;
                end
                mem_rdata      = $urandom;
                deq_ready      = ($urandom_range(0, 1) == 1);
                redirect_valid = ($urandom_range(0, 11) == 0);
                redirect_pc    = ($urandom_range(0, 5) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                             : $urandom;
            end
        endcase
    endtask

    task automatic cycle();
        drive_inputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic reset_mid_handshake();
        rst = 1'b1;
        #1;
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'(RESET_PC));
        check("rst_instr_valid", 64'(instr_valid), 64'd0);
        check("rst_instrF", 64'(instrF), 64'd0);
        check("rst_pcF", 64'(pcF), 64'd0);
        model_reset();
        r_wait = 0;
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b0;
    endtask

    initial begin
        bit rst_done;
        rst = 1'b1;
        mem_ack = 1'b0; mem_rdata = '0; redirect_valid = 1'b0;
        redirect_pc = '0; deq_ready = 1'b0;
        r_wait = 0; r_lat = 2; mode = 0; rst_done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_outputs();
        check("reset_mem_addr", 64'(mem_addr), 64'(RESET_PC));
        rst = 1'b0;

        // Fill with memory always ready and fetch stalled.
        mode = 0;
        repeat (8) cycle();
        check("full_mem_req_low", 64'(mem_req), 64'd0);
        check("full_head_pc", 64'(pcF), 64'(RESET_PC));
        check("full_head_instr", 64'(instrF), 64'(RESET_PC ^ 32'hA5A5_0000));

        // Streaming: one entry consumed and one fetched per cycle.
        mode = 1;
        repeat (12) begin
            cycle();
            check("stream_valid", 64'(instr_valid), 64'd1);
        end

        mode = 2;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            cycle();
            if (!rst_done && cyc > 300 && mem_req && m_q.size() == 2) begin
                reset_mid_handshake();
                rst_done = 1'b1;
                compare_outputs();
            end
        end
        if (!rst_done) begin
            reset_mid_handshake();
            compare_outputs();
        end
        repeat (20) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
